// File: rtl/iob_mp_reg_file_pkg.sv
// Shared definitions for the multi-port register file: FSM state codes,
// strobe-width derivation and the byte-merge helper used by the write path.
package iob_mp_reg_file_pkg;

  localparam logic IDLE  = 1'b0;
  localparam logic CLEAR = 1'b1;

  // Widest entry the merge helper handles; callers zero-extend into it.
  localparam int MAX_DATA_W = 128;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] new_v,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_v;
    for (int k = 0; k < MAX_STRB_W; k++) begin
      if (strb[k]) res[8*k +: 8] = new_v[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iob_mp_reg_file_rd_port.sv
// One registered read port: storage mux, optional same-cycle write bypass,
// and the r_data / r_valid output registers.
module iob_mp_reg_file_rd_port
  import iob_mp_reg_file_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter bit BYPASS = 1'b0,
  localparam int DEPTH = 2**ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
  input  logic                          wr_act,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_val,
  input  logic                          r_en,
  input  logic [ADDR_W-1:0]             r_addr,
  output logic [DATA_W-1:0]             r_data,
  output logic                          r_valid
);

  logic [DATA_W-1:0] rd_val;

  always_comb begin
    rd_val = mem[r_addr];
    if (BYPASS && wr_act && (wr_addr == r_addr)) rd_val = wr_val;
  end

  // stage boundary: request cycle -> registered read result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_en;
      if (r_en) r_data <= rd_val;
    end
  end

endmodule

// File: rtl/iob_mp_reg_file.sv
// Multi-port register file: byte-strobed write port, N_RD registered read ports,
// hardware clear sweep. Define IOB_MP_REG_FILE_BYPASS_EN for write-first reads.
module iob_mp_reg_file
  import iob_mp_reg_file_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int N_RD   = 2,
  localparam int STRB_W = strb_w(DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [STRB_W-1:0]        w_strb,
  input  logic [DATA_W-1:0]        w_data,
  input  logic [N_RD-1:0]          r_en,
  input  logic [N_RD*ADDR_W-1:0]   r_addr,
  output logic [N_RD*DATA_W-1:0]   r_data,
  output logic [N_RD-1:0]          r_valid
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef IOB_MP_REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic                         state;
  logic [ADDR_W-1:0]            idx;
  logic [DATA_W-1:0]            w_merged;
  logic                         wr_act;
  logic [ADDR_W-1:0]            wr_addr;
  logic [DATA_W-1:0]            wr_val;

  assign w_merged = DATA_W'(strb_merge(MAX_DATA_W'(mem[w_addr]), MAX_DATA_W'(w_data),
                                       MAX_STRB_W'(w_strb)));

  // The single storage update this cycle: a sweep clear, or a write that clr did not pre-empt.
  always_comb begin
    wr_act  = 1'b0;
    wr_addr = w_addr;
    wr_val  = w_merged;
    if (state == CLEAR) begin
      wr_act  = 1'b1;
      wr_addr = idx;
      wr_val  = '0;
    end else if (we && !clr) begin
      wr_act = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      state <= IDLE;
      idx   <= '0;
    end else begin
      if (wr_act) mem[wr_addr] <= wr_val;
      if (state == IDLE) begin
        if (clr) begin
          state <= CLEAR;
          idx   <= '0;
        end
      end else begin
        idx <= idx + 1'b1;
        if (idx == ADDR_W'(DEPTH - 1)) state <= IDLE;
      end
    end
  end

  assign busy = (state == CLEAR);

  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    iob_mp_reg_file_rd_port #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .BYPASS (BYPASS)
    ) u_rd (
      .clk     (clk),
      .rst     (rst),
      .mem     (mem),
      .wr_act  (wr_act),
      .wr_addr (wr_addr),
      .wr_val  (wr_val),
      .r_en    (r_en[i]),
      .r_addr  (r_addr[i*ADDR_W +: ADDR_W]),
      .r_data  (r_data[i*DATA_W +: DATA_W]),
      .r_valid (r_valid[i])
    );
  end

endmodule

// File: tb/tb_iob_mp_reg_file.sv
// Scoreboard bench for iob_mp_reg_file: reads push expected data per port,
// a negedge monitor pops and compares whenever r_valid is seen.
module tb_iob_mp_reg_file;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int N_RD   = 2;
`ifdef IOB_MP_REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic                   clr;
  logic                   busy;
  logic                   we;
  logic [ADDR_W-1:0]      w_addr;
  logic [DATA_W/8-1:0]    w_strb;
  logic [DATA_W-1:0]      w_data;
  logic [N_RD-1:0]        r_en;
  logic [N_RD*ADDR_W-1:0] r_addr;
  logic [N_RD*DATA_W-1:0] r_data;
  logic [N_RD-1:0]        r_valid;

  int total = 0;
  int bad   = 0;
  int cnt;
  logic [31:0] q [N_RD][$];

  iob_mp_reg_file #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_RD(N_RD)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .busy    (busy),
    .we      (we),
    .w_addr  (w_addr),
    .w_strb  (w_strb),
    .w_data  (w_data),
    .r_en    (r_en),
    .r_addr  (r_addr),
    .r_data  (r_data),
    .r_valid (r_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick();
    r_en = '0;
    we   = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
    we     = 1'b1;
    w_addr = a;
    w_data = d;
    w_strb = s;
  endtask

  task automatic rd(input int p, input logic [ADDR_W-1:0] a, input logic [31:0] e);
    r_en[p]               = 1'b1;
    r_addr[p*ADDR_W +: ADDR_W] = a;
    q[p].push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < N_RD; p++) begin
        if (r_valid[p]) begin
          if (q[p].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rvalid_p%0d actual=1 required=0", p);
          end else begin
            chk($sformatf("rdata_p%0d", p), r_data[p*DATA_W +: DATA_W], q[p].pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; we = 1'b0; w_addr = '0; w_strb = '0; w_data = '0;
    r_en = '0; r_addr = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", 32'(r_valid), 32'd0);
    chk("rst_rdata0", r_data[31:0], 32'd0);
    chk("rst_rdata1", r_data[63:32], 32'd0);

    // reset in the middle of a sweep after a write
    wr(3, 32'h12345678, 4'hF); step();
    clr = 1'b1; step();
    step(); step();
    chk("busy_in_sweep", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1 chk("busy_async_rst", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    rd(0, 3, 32'h0); rd(1, 3, 32'h0); step();

    // full write and byte-merged write
    wr(3, 32'hDEADBEEF, 4'hF); step();
    rd(0, 3, 32'hDEADBEEF); step();
    wr(3, 32'h0000AA00, 4'b0010); step();
    rd(0, 3, 32'hDEADAAEF); rd(1, 3, 32'hDEADAAEF); step();
    wr(3, 32'hFFFFFFFF, 4'h0); step();
    rd(1, 3, 32'hDEADAAEF); step();

    // read and write of the same address in one cycle
    wr(5, 32'h22222222, 4'hF); step();
    wr(5, 32'h11111111, 4'hF);
    rd(1, 5, BYP ? 32'h11111111 : 32'h22222222);
    rd(0, 3, 32'hDEADAAEF); step();
    rd(0, 5, 32'h11111111); step();

    // clear sweep: length, dropped write, reads while busy
    wr(20, 32'hABCD0000, 4'hF); step();
    clr = 1'b1; step();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) cnt++;
      if (i == 10) wr(3, 32'hFFFFFFFF, 4'hF);
      if (i == 3)  rd(0, 20, 32'hABCD0000);
      if (i == 20) rd(1, 20, BYP ? 32'h0 : 32'hABCD0000);
      if (i == 25) rd(0, 5, 32'h0);
      step();
    end
    chk("busy_cycles_sweep1", 32'(cnt), 32'd32);
    for (int a = 0; a < 32; a++) begin
      rd(0, 5'(a), 32'h0); rd(1, 5'(31 - a), 32'h0); step();
    end

    // clr and we together, second clr mid-sweep
    wr(7, 32'h77777777, 4'hF); step();
    rd(0, 7, 32'h77777777); step();
    clr = 1'b1; wr(7, 32'h00000055, 4'hF); step();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) cnt++;
      if (i == 5) clr = 1'b1;
      step();
    end
    chk("busy_cycles_sweep2", 32'(cnt), 32'd32);
    rd(0, 7, 32'h0); step();

    // reset at sweep index 10
    wr(9, 32'h99999999, 4'hF); step();
    wr(31, 32'h31313131, 4'hF); step();
    clr = 1'b1; step();
    repeat (9) step();
    r_en[0] = 1'b1; r_addr[4:0] = 5'd31;
    step();
    chk("busy_idx10", 32'(busy), 32'd1);
    chk("rvalid_before_rst", 32'(r_valid[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("busy_after_rst", 32'(busy), 32'd0);
    chk("rvalid_after_rst", 32'(r_valid), 32'd0);
    chk("rdata0_after_rst", r_data[31:0], 32'd0);
    tick();
    rst = 1'b0;
    rd(0, 9, 32'h0); rd(1, 31, 32'h0); step();
    rd(0, 20, 32'h0); rd(1, 3, 32'h0); step();

    repeat (3) step();
    chk("q0_drained", 32'(q[0].size()), 32'd0);
    chk("q1_drained", 32'(q[1].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
